// File: rtl/z_velocity_estimator_pkg.sv
// Shared constants, FSM state type and the deadband helper for the Z velocity estimator.
// Holds the accumulator width, the velocity output slice and the default parameter values.
package z_velocity_estimator_pkg;

    localparam int unsigned ACC_W              = 24;
    localparam int unsigned VEL_MSB            = 23;
    localparam int unsigned VEL_LSB            = 8;
    localparam int unsigned DEFAULT_DEADBAND   = 8;
    localparam int unsigned DEFAULT_TIMEOUT_US = 50000;
    localparam int unsigned DEFAULT_LEAK_SHIFT = 6;

    typedef enum logic [1:0] {
        WAIT_SAMPLE = 2'd0,
        ACCUM       = 2'd1,
        PUBLISH     = 2'd2
    } state_t;

    // Sign-extends a sample to accumulator width, or returns 0 when |s| <= db.
    function automatic logic signed [ACC_W-1:0] apply_deadband(input logic signed [15:0] s,
                                                               input int unsigned db);
        logic [16:0] mag;
        // 17 bits so that |-32768| is representable
        mag = s[15] ? (17'd0 - {1'b1, s}) : {1'b0, s};
        if (32'(mag) <= db) begin
            return '0;
        end
        return {{(ACC_W-16){s[15]}}, s};
    endfunction

endpackage

// File: rtl/z_velocity_estimator_if.sv
// Sample/publish bundle between the IMU side and the velocity estimator.
//   master: drives accel_z, accel_valid, imu_calibrated, zero_vel; reads the results.
//   slave : the estimator; drives z_linear_velocity, data_valid, imu_good, sample_overrun.
interface z_velocity_estimator_if;
    logic signed [15:0] accel_z;
    logic               accel_valid;
    logic               imu_calibrated;
    logic               zero_vel;
    logic signed [15:0] z_linear_velocity;
    logic               data_valid;
    logic               imu_good;
    logic               sample_overrun;

    modport master (
        output accel_z, accel_valid, imu_calibrated, zero_vel,
        input  z_linear_velocity, data_valid, imu_good, sample_overrun
    );

    modport slave (
        input  accel_z, accel_valid, imu_calibrated, zero_vel,
        output z_linear_velocity, data_valid, imu_good, sample_overrun
    );
endinterface

// File: rtl/z_vel_sat_add.sv
// 24-bit signed saturating adder (combinational).
//   a, b : signed addends
//   sum  : a + b clamped to [-8388608, +8388607]
module z_vel_sat_add
    import z_velocity_estimator_pkg::*;
(
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum
);
    logic signed [ACC_W:0] wide;

    assign wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};

    always_comb begin
        sum = wide[ACC_W-1:0];
        // Top two bits disagree only on overflow; the true sign is the MSB.
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/z_velocity_estimator.sv
// Integrates 100 Hz Z acceleration into a saturating 24-bit velocity accumulator.
//   us_clk, resetn : 1 MHz clock, asynchronous active-low reset
//   bus (slave)    : accel_z/accel_valid in; z_linear_velocity (acc[23:8]), data_valid strobe,
//                    imu_good, sticky sample_overrun out
// Optional build macro Z_VEL_LEAK_EN adds a decay of acc >>> LEAK_SHIFT each sample.
module z_velocity_estimator
    import z_velocity_estimator_pkg::*;
#(
    parameter int unsigned DEADBAND   = DEFAULT_DEADBAND,
    parameter int unsigned TIMEOUT_US = DEFAULT_TIMEOUT_US,
    parameter int unsigned LEAK_SHIFT = DEFAULT_LEAK_SHIFT
) (
    input logic              us_clk,
    input logic              resetn,
    z_velocity_estimator_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT_US + 1);

    // A zero shift would negate the whole accumulator and could hit -(-2^23).
    if (LEAK_SHIFT < 1 || LEAK_SHIFT >= ACC_W) begin : g_bad_leak_shift
        $error("LEAK_SHIFT out of range");
    end

    state_t                   state_q, state_d;
    logic signed [15:0]       sample_q, sample_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     good_q, good_d;
    logic                     overrun_q, overrun_d;
    logic                     accept;
    logic signed [ACC_W-1:0]  leaked;
    logic signed [ACC_W-1:0]  acc_sum;

`ifdef Z_VEL_LEAK_EN
    logic signed [ACC_W-1:0] leak_neg;
    assign leak_neg = -(acc_q >>> LEAK_SHIFT);
    z_vel_sat_add u_leak (
        .a   (acc_q),
        .b   (leak_neg),
        .sum (leaked)
    );
`else
    assign leaked = acc_q;
`endif

    z_vel_sat_add u_add (
        .a   (leaked),
        .b   (apply_deadband(sample_q, DEADBAND)),
        .sum (acc_sum)
    );

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        acc_d     = acc_q;
        accept    = 1'b0;
        overrun_d = overrun_q | (bus.accel_valid && (state_q != WAIT_SAMPLE));
        if (bus.zero_vel) begin
            state_d = WAIT_SAMPLE;
            acc_d   = '0;
        end else begin
            case (state_q)
                WAIT_SAMPLE: begin
                    if (bus.accel_valid) begin
                        accept   = 1'b1;
                        sample_d = bus.accel_z;
                        state_d  = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_d   = acc_sum;
                    state_d = PUBLISH;
                end
                PUBLISH: state_d = WAIT_SAMPLE;
                default: state_d = WAIT_SAMPLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (cnt_q != CntW'(TIMEOUT_US)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        good_d = good_q;
        if ((state_q == PUBLISH) && !bus.zero_vel && bus.imu_calibrated) begin
            good_d = 1'b1;
        end
        if ((cnt_q == CntW'(TIMEOUT_US)) || !bus.imu_calibrated) begin
            good_d = 1'b0;
        end
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= WAIT_SAMPLE;
            sample_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            good_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            overrun_q <= overrun_d;
        end
    end

    // Accumulator only moves on entry to PUBLISH (or on a clear), so the slice is stable between strobes.
    assign bus.z_linear_velocity = acc_q[VEL_MSB:VEL_LSB];
    assign bus.data_valid        = (state_q == PUBLISH) && !bus.zero_vel;
    assign bus.imu_good          = good_q;
    assign bus.sample_overrun    = overrun_q;

endmodule

// File: tb/tb_z_velocity_estimator.sv
module tb_z_velocity_estimator;
    localparam int unsigned DB = 8;
    localparam int unsigned TO = 50000;
    localparam int unsigned LS = 6;

    logic us_clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;

    z_velocity_estimator_if bus ();

    z_velocity_estimator #(
        .DEADBAND   (DB),
        .TIMEOUT_US (TO),
        .LEAK_SHIFT (LS)
    ) dut (
        .us_clk (us_clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 us_clk = ~us_clk;
    always @(posedge us_clk) cyc <= cyc + 1;

    typedef struct {
        int vel;
        int at;
    } exp_t;

    exp_t   q[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    longint acc_m = 0;
    int     busy_until = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint clamp24(input longint x);
        if (x > 64'sd8388607) return 64'sd8388607;
        if (x < -64'sd8388608) return -64'sd8388608;
        return x;
    endfunction

    // Reference: one accepted sample changes the velocity accumulator.
    function automatic void model_sample(input int v);
        longint a;
        a = (v < 0) ? -v : v;
        if (a <= DB) a = 0;
        else a = v;
`ifdef Z_VEL_LEAK_EN
        acc_m = clamp24(acc_m - (acc_m >>> LS));
`endif
        acc_m = clamp24(acc_m + a);
    endfunction

    function automatic int model_vel();
        return int'(acc_m >>> 8);
    endfunction

    // Monitor: every data_valid must match the oldest outstanding expectation.
    always @(negedge us_clk) begin
        if (resetn && bus.data_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_data_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("publish_velocity", bus.z_linear_velocity, e.vel);
                chk("publish_latency_cycle", cyc, e.at);
            end
        end
    end

    // One-cycle strobe, then 'extra' idle cycles; returns the strobe cycle.
    task automatic strobe(input int v, input int extra, output int s);
        @(posedge us_clk);
        #1;
        bus.accel_z     = 16'(v);
        bus.accel_valid = 1'b1;
        s = cyc;
        if (cyc >= busy_until) begin
            model_sample(v);
            q.push_back('{vel: model_vel(), at: cyc + 2});
            busy_until = cyc + 3;
        end
        @(posedge us_clk);
        #1;
        bus.accel_valid = 1'b0;
        repeat (extra) @(posedge us_clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge us_clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.accel_z        = '0;
        bus.accel_valid    = 1'b0;
        bus.imu_calibrated = 1'b1;
        bus.zero_vel       = 1'b0;
        #23;
        chk("reset_velocity", bus.z_linear_velocity, 0);
        chk("reset_data_valid", bus.data_valid, 0);
        chk("reset_imu_good", bus.imu_good, 0);
        chk("reset_overrun", bus.sample_overrun, 0);
        @(posedge us_clk);
        #1;
        resetn = 1'b1;

        // Steady integration: 256 x 100 -> 25600 -> velocity 100.
        for (int i = 0; i < 256; i++) strobe(100, 1, s);
        @(negedge us_clk);
        chk("accum_256x100", bus.z_linear_velocity, 100);
        chk("imu_good_after_publish", bus.imu_good, 1);

        // Deadband: values within +-8 leave the accumulator unchanged but still publish.
        strobe(8, 1, s);
        strobe(-5, 1, s);
        strobe(-8, 1, s);
        strobe(9, 1, s);
        @(negedge us_clk);
        chk("deadband_then_9", bus.z_linear_velocity, model_vel());

        // Positive saturation.
        for (int i = 0; i < 300; i++) strobe(32767, 1, s);
        @(negedge us_clk);
        chk("sat_positive", bus.z_linear_velocity, 32767);

        // zero_vel wins over a same-cycle accel_valid: cleared, no strobe.
        @(posedge us_clk);
        #1;
        bus.zero_vel    = 1'b1;
        bus.accel_valid = 1'b1;
        bus.accel_z     = 16'sd1000;
        acc_m = 0;
        @(posedge us_clk);
        #1;
        bus.zero_vel    = 1'b0;
        bus.accel_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge us_clk);
            chk("zero_vel_velocity", bus.z_linear_velocity, 0);
            chk("zero_vel_no_data_valid", bus.data_valid, 0);
        end
        chk("overrun_still_clear", bus.sample_overrun, 0);

        // Negative saturation from zero.
        for (int i = 0; i < 300; i++) strobe(-32768, 1, s);
        @(negedge us_clk);
        chk("sat_negative", bus.z_linear_velocity, -32768);

        // Timeout: one sample, then silence.
        strobe(200, 0, s);
        wait_until(s + 4);
        chk("timeout_good_after_sample", bus.imu_good, 1);
        wait_until(s + TO - 5);
        chk("timeout_good_before_limit", bus.imu_good, 1);
        wait_until(s + TO + 5);
        chk("timeout_good_dropped", bus.imu_good, 0);
        strobe(300, 0, s);
        wait_until(s + 4);
        chk("timeout_good_restored", bus.imu_good, 1);

        // Calibration loss clears imu_good and a publish cannot set it.
        bus.imu_calibrated = 1'b0;
        strobe(50, 1, s);
        @(negedge us_clk);
        chk("uncalibrated_good", bus.imu_good, 0);
        bus.imu_calibrated = 1'b1;

        // Strobe during ACCUM is dropped and flags overrun.
        strobe(1000, 0, s);
        strobe(2000, 3, s);
        @(negedge us_clk);
        chk("overrun_set", bus.sample_overrun, 1);
        chk("overrun_velocity", bus.z_linear_velocity, model_vel());

        // Randomized samples and gaps (gap 0 produces further drops).
        for (int i = 0; i < 400; i++) begin
            int v;
            int g;
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 16)) - 8;
                1: v = int'($urandom_range(0, 65535)) - 32768;
                2: v = int'($urandom_range(0, 4000)) - 2000;
                default: v = (($urandom_range(0, 1) == 1) ? 32767 : -32768);
            endcase
            g = int'($urandom_range(0, 3));
            strobe(v, g, s);
        end
        repeat (3) @(posedge us_clk);
        @(negedge us_clk);
        chk("random_final_velocity", bus.z_linear_velocity, model_vel());
        chk("random_queue_drained", q.size(), 0);

        // Reset mid-operation aborts the in-flight sample.
        strobe(5000, 0, s);
        #1;
        resetn = 1'b0;
        #1;
        chk("midreset_velocity", bus.z_linear_velocity, 0);
        chk("midreset_data_valid", bus.data_valid, 0);
        chk("midreset_overrun", bus.sample_overrun, 0);
        chk("midreset_imu_good", bus.imu_good, 0);
        q.delete();
        acc_m = 0;
        busy_until = 0;
        @(posedge us_clk);
        #1;
        resetn = 1'b1;
        repeat (5) begin
            @(negedge us_clk);
            chk("post_reset_no_data_valid", bus.data_valid, 0);
        end
        strobe(-700, 2, s);
        @(negedge us_clk);
        chk("post_reset_velocity", bus.z_linear_velocity, model_vel());
        chk("final_queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
